fifo_sync: RTL and testbench
============================

// Module: fifo_sync
// PURPOSE
//  Synchronous FIFO that buffers 10-bit words ahead of the contador stage. Writer pushes
//  data_in, downstream pops. Each accepted pop produces one data_out/valid_out beat, which
//  the contador consumes as its count event. Exports full/empty/almost flags for
//  upstream flow control and a sticky error flag.
// PARAMETERS
//  DATA_WIDTH     10  word width
//  ADDR_WIDTH     3   pointer width; depth = 2**ADDR_WIDTH = 8
//  ALM_FULL_THR   6   almost_full asserted when count >= ALM_FULL_THR
//  ALM_EMPTY_THR  1   almost_empty asserted when count <= ALM_EMPTY_THR
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  rst           in   1             synchronous reset, active-low (0 = reset)
//  push          in   1             write request, sampled on posedge
//  pop           in   1             read request, sampled on posedge
//  data_in       in   DATA_WIDTH    write data, sampled with push
//  data_out      out  DATA_WIDTH    registered read data
//  valid_out     out  1             data_out holds a popped word this cycle
//  count         out  ADDR_WIDTH+1  occupancy, 0..2**ADDR_WIDTH
//  full          out  1             count == 2**ADDR_WIDTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= ALM_FULL_THR
//  almost_empty  out  1             count <= ALM_EMPTY_THR
//  fifo_error    out  1             sticky: overflow or underflow attempt seen
// BEHAVIOUR
//  - Reset (rst==0 at posedge): wr_ptr=rd_ptr=0, count=0, data_out=0, valid_out=0,
//    fifo_error=0. Flags then read empty=1, almost_empty=1, full=0, almost_full=0.
//    Memory contents are not cleared. Reset overrides push/pop in the same cycle.
//  - Flags decode combinationally from the count register, so they are valid in the
//    same cycle as count.
//  - Push accepted iff push && (!full || pop): mem[wr_ptr]<=data_in, wr_ptr+1.
//  - Pop accepted iff pop && !empty: data_out<=mem[rd_ptr], rd_ptr+1.
//    valid_out=1 in the cycle after the accepting edge (latency 1).
//  - Cycle with no accepted pop: valid_out<=0; data_out holds its last value.
//  - count: +1 on push-only, -1 on pop-only, unchanged on both or neither.
//  - Pointers wrap modulo 2**ADDR_WIDTH. Full/empty come from count, never from a
//    pointer compare.
//  - push && full && !pop: write dropped, state unchanged, fifo_error<=1.
//  - pop && empty: pop ignored, valid_out<=0, fifo_error<=1. This applies even with a
//    concurrent push (no bypass); that push is still accepted.
//  - push && pop while full: both accepted, count stays at max. The popped word is the
//    oldest one, never the incoming one.
//  - fifo_error clears only on reset.
//  - Reset mid-stream discards all buffered words. The first pop after reset with no
//    push returns an error, not stale data.
// STRUCTURE
//  - Shared header fifo_defs.vh: default DATA_WIDTH/ADDR_WIDTH and thresholds, reused
//    by contador and the arbiter.
//  - Sub-module mem_dp: dual-port register array, one synchronous write port and one
//    synchronous read port (wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data).
//    fifo_sync holds the pointers, count, flags and error logic.
//  - Testbench split into probador (stimulus) and banco (instantiation/dump), as for
//    the other blocks.
// TESTING
//  1 rst=0 two cycles, then rst=1 -> count=0, empty=1, almost_empty=1, full=0,
//    valid_out=0, fifo_error=0.
//  2 push 25,45,65 on consecutive cycles -> count 1,2,3; almost_empty drops when
//    count=2; no valid_out.
//  3 from count=0, push 25,45,...,165 (8 words) -> almost_full at count=6, full at
//    count=8; 9th push of 185 -> dropped, fifo_error=1, count=8.
//  4 pop 8 times from full -> data_out 25,45,...,165, each one cycle after its pop;
//    empty=1 after the last; extra pop -> valid_out=0, data_out stays 165.
//  5 at count=8, push 200 and pop together -> data_out=oldest word, count=8, full=1,
//    no new error; at count=0, push 30 and pop together -> count=1, valid_out=0,
//    fifo_error=1.
//  6 reset asserted at count=5 -> next cycle count=0, empty=1, fifo_error=0;
//    push 77 then pop -> data_out=77, valid_out=1.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared defaults and helpers for the synchronous FIFO slice.
// Widths, thresholds and the push/pop operation encoding.
package fifo_sync_pkg;

  localparam int DATA_WIDTH_D    = 10;
  localparam int ADDR_WIDTH_D    = 3;
  localparam int ALM_FULL_THR_D  = 6;
  localparam int ALM_EMPTY_THR_D = 1;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_t;

  function automatic fifo_op_t op_of(
    input logic wr,
    input logic rd
  );
    return fifo_op_t'({rd, wr});
  endfunction

endpackage

// File: rtl/fifo_sync_mem_dp.sv
// Dual-port register array: one sync write port, one sync read port.
// Ports: clk, rst (sync, active-low, clears rd_data only), wr_*, rd_*.
module fifo_sync_mem_dp
  import fifo_sync_pkg::*;
#(
  parameter int DW = DATA_WIDTH_D,
  parameter int AW = ADDR_WIDTH_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Read sees the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO feeding the contador stage.
// Ports: clk, rst (sync active-low), push/pop/data_in in; data_out,
// valid_out, count, full, empty, almost_full, almost_empty, fifo_error out.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_D,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_D,
  parameter int ALM_FULL_THR  = ALM_FULL_THR_D,
  parameter int ALM_EMPTY_THR = ALM_EMPTY_THR_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam logic [ADDR_WIDTH:0] DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_T  = ALM_FULL_THR[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_T  = ALM_EMPTY_THR[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic                  ovf;
  logic                  udf;
  fifo_op_t              op;

  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  // A pop frees a slot, so push into a full FIFO is fine alongside it.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign ovf     = push && full && !pop;
  assign udf     = pop && empty;
  assign op      = op_of(do_push, do_pop);

  fifo_sync_mem_dp #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (do_push && rst),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (do_pop),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      valid_out <= do_pop;
      if (ovf || udf)
        fifo_error <= 1'b1;
      unique case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        OP_NONE: count <= count;
        OP_BOTH: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync.
// Directed scenarios plus random traffic against a queue model.
module tb_fifo_sync;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       valid_out;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;

  int total = 0;
  int bad   = 0;

  logic [9:0] mq[$];
  logic [9:0] m_dout;
  logic       m_valid;
  logic       m_err;

  fifo_sync dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(
    input logic r, input logic p, input logic q, input logic [9:0] d
  );
    int n;
    n = mq.size();
    if (!r) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      if ((q && n == 0) || (p && !q && n == 8))
        m_err = 1'b1;
      if (q && n > 0) begin
        m_dout  = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (p && (n < 8 || q))
        mq.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == 8));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= 6));
    chk("almost_empty", int'(almost_empty), int'(n <= 1));
    chk("valid_out", int'(valid_out), int'(m_valid));
    chk("data_out", int'(data_out), int'(m_dout));
    chk("fifo_error", int'(fifo_error), int'(m_err));
  endtask

  task automatic cyc(
    input logic r, input logic p, input logic q, input logic [9:0] d
  );
    rst     = r;
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    model_step(r, p, q, d);
    #1;
    check_all();
  endtask

  initial begin
    logic [9:0] w;
    int pp;
    rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0;

    // 1: reset
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t1_count", int'(count), 0);
    chk("t1_empty", int'(empty), 1);
    chk("t1_ae", int'(almost_empty), 1);
    cyc(1, 0, 0, 0);

    // 2: three pushes
    cyc(1, 1, 0, 25);
    chk("t2_ae1", int'(almost_empty), 1);
    cyc(1, 1, 0, 45);
    chk("t2_ae2", int'(almost_empty), 0);
    cyc(1, 1, 0, 65);
    chk("t2_cnt", int'(count), 3);
    chk("t2_vld", int'(valid_out), 0);

    // 3: fill to full then overflow
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      w = 10'(25 + 20 * i);
      cyc(1, 1, 0, w);
      if (i == 5) chk("t3_af6", int'(almost_full), 1);
    end
    chk("t3_full", int'(full), 1);
    chk("t3_err0", int'(fifo_error), 0);
    cyc(1, 1, 0, 185);
    chk("t3_err1", int'(fifo_error), 1);
    chk("t3_cnt", int'(count), 8);

    // 4: drain in order, then underflow
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 1, 0);
      chk("t4_vld", int'(valid_out), 1);
      chk("t4_dat", int'(data_out), 25 + 20 * i);
    end
    chk("t4_empty", int'(empty), 1);
    cyc(1, 0, 1, 0);
    chk("t4_xvld", int'(valid_out), 0);
    chk("t4_xdat", int'(data_out), 165);

    // 5: push+pop at full, then at empty
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      w = 10'(25 + 20 * i);
      cyc(1, 1, 0, w);
    end
    cyc(1, 1, 1, 200);
    chk("t5_dat", int'(data_out), 25);
    chk("t5_cnt", int'(count), 8);
    chk("t5_full", int'(full), 1);
    chk("t5_err", int'(fifo_error), 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0);
    chk("t5_last", int'(data_out), 200);
    cyc(1, 1, 1, 30);
    chk("t5_cnt1", int'(count), 1);
    chk("t5_vld0", int'(valid_out), 0);
    chk("t5_err1", int'(fifo_error), 1);

    // 6: reset mid-stream
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 10'(300 + i));
    cyc(0, 0, 0, 0);
    chk("t6_cnt", int'(count), 0);
    chk("t6_err", int'(fifo_error), 0);
    cyc(1, 0, 1, 0);
    chk("t6_uerr", int'(fifo_error), 1);
    cyc(1, 1, 0, 77);
    cyc(1, 0, 1, 0);
    chk("t6_dat", int'(data_out), 77);
    chk("t6_vld", int'(valid_out), 1);

    // random traffic, alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 600; i++) begin
      pp = ((i / 50) % 2 == 0) ? 70 : 30;
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 99) < pp),
          ($urandom_range(0, 99) < 100 - pp),
          10'($urandom_range(0, 1023)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
